wb_slave_router: RTL and testbench
==================================

# wb_slave_router

Registered Wishbone classic router between the management SoC Wishbone slave port and the user-area peripherals: the user project (`user_proj_example`) and the UART. It replaces combinational address gating and ack-ORing with a one-outstanding-transaction FSM. The FSM latches each request, forwards it to exactly one decoded target and returns exactly one registered ack. Unmapped addresses and hung slaves get an error response instead of stalling the CPU.

## Interface

Parameters:
- `USR_BASE_A`, default 12'h380: `adr[31:20]` region routed to the user project.
- `USR_BASE_B`, default 12'h320: second user-project region.
- `USR_BASE_C`, default 12'h340: third user-project region.
- `UART_BASE`, default 12'h300: `adr[31:20]` region routed to the UART.
- `TIMEOUT_CYC`, default 255: forward-phase cycle limit, 1..65535.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on error.

Ports:
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_i`, in, 1: asynchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`, in, 1 each: master request.
- `wbs_sel_i`, in, 4; `wbs_adr_i`, in, 32; `wbs_dat_i`, in, 32: master request fields.
- `wbs_ack_o`, out, 1: one-cycle registered ack to the master.
- `wbs_dat_o`, out, 32: registered read data.
- `usr_cyc_o`, `usr_stb_o`, `usr_we_o`, out, 1 each: user-project request.
- `usr_sel_o`, out, 4; `usr_adr_o`, out, 32; `usr_dat_o`, out, 32: user-project request fields.
- `usr_ack_i`, in, 1; `usr_dat_i`, in, 32: user-project response.
- `uart_cyc_o` … `uart_dat_o`, `uart_ack_i`, `uart_dat_i`: same set for the UART.
- `bus_err_o`, out, 1: one-cycle pulse, coincident with an error ack.
- `err_code_o`, out, 2: 00 none, 01 unmapped, 10 timeout. Held until the next accepted request.

## Operation

FSM states: IDLE, FWD, RESP.

- IDLE:
  - On `wbs_cyc_i & wbs_stb_i`, register we/sel/adr/dat and the decoded target (USR, UART, NONE), and clear `err_code_o`.
  - Target USR or UART → FWD.
  - Target NONE → RESP with data `ERR_DATA`, `err_code_o`=01.
- FWD:
  - The selected slave sees cyc=stb=1 and the latched fields. The non-selected slave sees all-zero outputs.
  - The timeout counter increments each cycle.
  - The ack from the selected slave is captured together with its `dat_i` → RESP, `err_code_o` unchanged.
  - An ack from the non-selected slave is ignored.
  - Counter reaches `TIMEOUT_CYC` without ack → drop slave cyc/stb, data `ERR_DATA`, `err_code_o`=10 → RESP.
  - Master abort (`wbs_cyc_i`=0): drop slave cyc/stb, no ack → IDLE.
- RESP:
  - `wbs_ack_o`=1 for exactly one cycle, `wbs_dat_o` = captured data.
  - `bus_err_o`=1 if the response is an error.
  - → IDLE unconditionally.
- Writes return `wbs_dat_o`=0 on success and `ERR_DATA` on error.
- Decode compares `adr[31:20]` only; the lower bits pass through unmodified.
- In IDLE and RESP, all slave outputs are 0.

Reset values (asynchronous, immediate, including mid-transaction):
- State IDLE; counter 0.
- All `*_o` 0, `err_code_o`=00.
- The in-flight transaction is dropped with no ack.

## Timing

- Request sampled at edge 0 → slave cyc/stb high in cycle 1.
- Slave ack sampled at edge k (k≥1) → `wbs_ack_o` high in cycle k+1. Minimum request-to-ack latency is 2 cycles.
- Unmapped address: ack in cycle 1.
- Timeout: ack in cycle `TIMEOUT_CYC`+1 after the request.
- Slave cyc/stb fall in the cycle after the slave ack.
- After RESP, IDLE re-samples stb in the next cycle, so a back-to-back request costs no bubble beyond RESP.
- One transaction in flight at a time; master request fields are ignored outside IDLE.

## Configuration

`WB_SLAVE_ROUTER_TIMEOUT_EN`:
- Defined: the timeout counter and the timeout error path (code 10) are present.
- Undefined: no counter; FWD waits for the slave ack or a master abort indefinitely; `err_code_o` can only be 00 or 01.

## Structure

- Package `wb_router_pkg`: state enum (IDLE/FWD/RESP), target enum (NONE/USR/UART), error code constants, default `ERR_DATA`.
- Sub-module `wb_addr_decode`: combinational `adr[31:20]` → target, parameterised by the four bases.
- The FSM, latches and counter live in `wb_slave_router`.

## Test plan

- Read 0x3000_0004; UART acks 3 cycles after stb with 32'h0000_0041 → `wbs_ack_o` one cycle later, `wbs_dat_o`=32'h41; `usr_*` all 0 throughout.
- Write 0x3800_0010, data 32'h1234_5678, sel 4'hF → `usr_adr_o`/`usr_dat_o` match; single ack; `err_code_o`=00.
- Read 0x2000_0000 → ack in cycle 1, `wbs_dat_o`=32'hDEAD_BEEF, `bus_err_o` pulse, `err_code_o`=01; no slave strobed.
- With `TIMEOUT_CYC`=8 and the UART never acking → error ack in cycle 9, `err_code_o`=10, `uart_stb_o` dropped. With the macro undefined → no ack after 1000 cycles.
- Drop `wbs_cyc_i` in FWD → slave cyc/stb fall next cycle, no `wbs_ack_o`. Assert `wb_rst_i` mid-FWD → all outputs 0 immediately, FSM in IDLE.
- Back-to-back reads 0x3200_0000 then 0x3000_0000 → two acks, each one cycle wide, correct data each; a spurious `usr_ack_i` during the UART transaction is ignored.

Source files
------------

// File: rtl/wb_router_pkg.sv
// Shared types and constants for the Wishbone slave router.
// Optional timeout path is enabled by WB_SLAVE_ROUTER_TIMEOUT_EN.
package wb_router_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_USR  = 2'd1,
        TGT_UART = 2'd2
    } tgt_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational page decode: adr[31:20] to router target.
// Part of wb_slave_router (macro WB_SLAVE_ROUTER_TIMEOUT_EN unused here).
module wb_addr_decode
    import wb_router_pkg::*;
#(
    parameter logic [11:0] USR_BASE_A = 12'h380,
    parameter logic [11:0] USR_BASE_B = 12'h320,
    parameter logic [11:0] USR_BASE_C = 12'h340,
    parameter logic [11:0] UART_BASE  = 12'h300
) (
    input  logic [11:0] page_i,
    output logic [1:0]  tgt_o
);

    always_comb begin
        tgt_o = TGT_NONE;
        if (page_i == USR_BASE_A || page_i == USR_BASE_B ||
            page_i == USR_BASE_C) begin
            tgt_o = TGT_USR;
        end else if (page_i == UART_BASE) begin
            tgt_o = TGT_UART;
        end
    end

endmodule

// File: rtl/wb_slave_router.sv
// One-outstanding Wishbone classic router: user project and UART.
// Define WB_SLAVE_ROUTER_TIMEOUT_EN to add the forward-phase timeout.
module wb_slave_router
    import wb_router_pkg::*;
#(
    parameter logic [11:0] USR_BASE_A  = 12'h380,
    parameter logic [11:0] USR_BASE_B  = 12'h320,
    parameter logic [11:0] USR_BASE_C  = 12'h340,
    parameter logic [11:0] UART_BASE   = 12'h300,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        usr_cyc_o,
    output logic        usr_stb_o,
    output logic        usr_we_o,
    output logic [3:0]  usr_sel_o,
    output logic [31:0] usr_adr_o,
    output logic [31:0] usr_dat_o,
    input  logic        usr_ack_i,
    input  logic [31:0] usr_dat_i,
    output logic        uart_cyc_o,
    output logic        uart_stb_o,
    output logic        uart_we_o,
    output logic [3:0]  uart_sel_o,
    output logic [31:0] uart_adr_o,
    output logic [31:0] uart_dat_o,
    input  logic        uart_ack_i,
    input  logic [31:0] uart_dat_i,
    output logic        bus_err_o,
    output logic [1:0]  err_code_o
);

    logic [1:0]  state_q, state_d;
    logic [1:0]  tgt_q, tgt_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;
    logic        berr_q, berr_d;
    logic [1:0]  ecode_q, ecode_d;
    logic [1:0]  dec_tgt;
    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        to_hit;
    logic        fwd_usr;
    logic        fwd_uart;

    wb_addr_decode #(
        .USR_BASE_A (USR_BASE_A),
        .USR_BASE_B (USR_BASE_B),
        .USR_BASE_C (USR_BASE_C),
        .UART_BASE  (UART_BASE)
    ) u_dec (
        .page_i (wbs_adr_i[31:20]),
        .tgt_o  (dec_tgt)
    );

`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
    logic [15:0] cnt_q;

    // Counter is zero on entry to FWD and counts elapsed FWD cycles.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (state_q == ST_FWD) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign to_hit = (cnt_q + 16'd1) == 16'(TIMEOUT_CYC);
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT_CYC);
    assign to_hit = 1'b0;
`endif

    assign fwd_usr  = (state_q == ST_FWD) && (tgt_q == TGT_USR);
    assign fwd_uart = (state_q == ST_FWD) && (tgt_q == TGT_UART);

    assign sel_ack = fwd_usr ? usr_ack_i : uart_ack_i;
    assign sel_dat = fwd_usr ? usr_dat_i : uart_dat_i;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        dat_d   = '0;
        ack_d   = 1'b0;
        berr_d  = 1'b0;
        ecode_d = ecode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    tgt_d   = dec_tgt;
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    adr_d   = wbs_adr_i;
                    wdat_d  = wbs_dat_i;
                    ecode_d = ERR_NONE;
                    if (dec_tgt == TGT_NONE) begin
                        state_d = ST_RESP;
                        dat_d   = ERR_DATA;
                        ack_d   = 1'b1;
                        berr_d  = 1'b1;
                        ecode_d = ERR_UNMAPPED;
                    end else begin
                        state_d = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    state_d = ST_RESP;
                    dat_d   = we_q ? 32'd0 : sel_dat;
                    ack_d   = 1'b1;
                end else if (to_hit) begin
                    state_d = ST_RESP;
                    dat_d   = ERR_DATA;
                    ack_d   = 1'b1;
                    berr_d  = 1'b1;
                    ecode_d = ERR_TIMEOUT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_NONE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            berr_q  <= 1'b0;
            ecode_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            berr_q  <= berr_d;
            ecode_q <= ecode_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign bus_err_o  = berr_q;
    assign err_code_o = ecode_q;

    assign usr_cyc_o  = fwd_usr;
    assign usr_stb_o  = fwd_usr;
    assign usr_we_o   = fwd_usr & we_q;
    assign usr_sel_o  = fwd_usr ? sel_q : 4'd0;
    assign usr_adr_o  = fwd_usr ? adr_q : 32'd0;
    assign usr_dat_o  = fwd_usr ? wdat_q : 32'd0;

    assign uart_cyc_o = fwd_uart;
    assign uart_stb_o = fwd_uart;
    assign uart_we_o  = fwd_uart & we_q;
    assign uart_sel_o = fwd_uart ? sel_q : 4'd0;
    assign uart_adr_o = fwd_uart ? adr_q : 32'd0;
    assign uart_dat_o = fwd_uart ? wdat_q : 32'd0;

endmodule

// File: tb/tb_wb_slave_router.sv
// Bench for wb_slave_router: transaction model plus directed vectors.
// Timeout vectors follow WB_SLAVE_ROUTER_TIMEOUT_EN.
module tb_wb_slave_router;

    localparam int TO = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
    logic [3:0]  wbs_sel_i = 0;
    logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        usr_cyc_o, usr_stb_o, usr_we_o;
    logic [3:0]  usr_sel_o;
    logic [31:0] usr_adr_o, usr_dat_o;
    logic        usr_ack_i = 0;
    logic [31:0] usr_dat_i = 0;
    logic        uart_cyc_o, uart_stb_o, uart_we_o;
    logic [3:0]  uart_sel_o;
    logic [31:0] uart_adr_o, uart_dat_o;
    logic        uart_ack_i = 0;
    logic [31:0] uart_dat_i = 0;
    logic        bus_err_o;
    logic [1:0]  err_code_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_slave_router #(.TIMEOUT_CYC(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .usr_cyc_o(usr_cyc_o), .usr_stb_o(usr_stb_o), .usr_we_o(usr_we_o),
        .usr_sel_o(usr_sel_o), .usr_adr_o(usr_adr_o), .usr_dat_o(usr_dat_o),
        .usr_ack_i(usr_ack_i), .usr_dat_i(usr_dat_i),
        .uart_cyc_o(uart_cyc_o), .uart_stb_o(uart_stb_o), .uart_we_o(uart_we_o),
        .uart_sel_o(uart_sel_o), .uart_adr_o(uart_adr_o), .uart_dat_o(uart_dat_o),
        .uart_ack_i(uart_ack_i), .uart_dat_i(uart_dat_i),
        .bus_err_o(bus_err_o), .err_code_o(err_code_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: 0=none, 1=user, 2=uart
    function automatic int target_of(input logic [31:0] a);
        int pg;
        pg = int'(a >> 20);
        if (pg == 'h380 || pg == 'h320 || pg == 'h340) return 1;
        if (pg == 'h300) return 2;
        return 0;
    endfunction

    bit          m_busy, m_resp, m_rerr, m_we;
    int          m_tgt, m_age;
    logic [1:0]  m_ecode;
    logic [31:0] m_rdata, m_adr, m_wd;
    logic [3:0]  m_sel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_resp = 0; m_rerr = 0; m_we = 0;
            m_tgt = 0; m_age = 0; m_ecode = 0;
            m_rdata = 0; m_adr = 0; m_wd = 0; m_sel = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (!wbs_cyc_i) begin
                m_busy = 0;
            end else if ((m_tgt == 1) ? usr_ack_i : uart_ack_i) begin
                m_busy = 0; m_resp = 1; m_rerr = 0;
                m_rdata = m_we ? 32'd0 : ((m_tgt == 1) ? usr_dat_i : uart_dat_i);
            end else begin
                m_age++;
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
                if (m_age == TO) begin
                    m_busy = 0; m_resp = 1; m_rerr = 1;
                    m_rdata = ERRD; m_ecode = 2'b10;
                end
`endif
            end
        end else if (wbs_cyc_i && wbs_stb_i) begin
            m_tgt = target_of(wbs_adr_i);
            m_we = wbs_we_i; m_sel = wbs_sel_i;
            m_adr = wbs_adr_i; m_wd = wbs_dat_i;
            m_age = 0; m_ecode = 0;
            if (m_tgt == 0) begin
                m_resp = 1; m_rerr = 1; m_rdata = ERRD; m_ecode = 2'b01;
            end else begin
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit eu, ea;
            eu = m_busy && m_tgt == 1;
            ea = m_busy && m_tgt == 2;
            chk("wbs_ack", 32'(wbs_ack_o), 32'(m_resp));
            chk("wbs_dat", wbs_dat_o, m_resp ? m_rdata : 32'd0);
            chk("bus_err", 32'(bus_err_o), 32'(m_resp && m_rerr));
            chk("err_code", 32'(err_code_o), 32'(m_ecode));
            chk("usr_cyc", 32'(usr_cyc_o), 32'(eu));
            chk("usr_stb", 32'(usr_stb_o), 32'(eu));
            chk("usr_we", 32'(usr_we_o), 32'(eu && m_we));
            chk("usr_sel", 32'(usr_sel_o), eu ? 32'(m_sel) : 32'd0);
            chk("usr_adr", usr_adr_o, eu ? m_adr : 32'd0);
            chk("usr_dat", usr_dat_o, eu ? m_wd : 32'd0);
            chk("uart_cyc", 32'(uart_cyc_o), 32'(ea));
            chk("uart_stb", 32'(uart_stb_o), 32'(ea));
            chk("uart_we", 32'(uart_we_o), 32'(ea && m_we));
            chk("uart_sel", 32'(uart_sel_o), ea ? 32'(m_sel) : 32'd0);
            chk("uart_adr", uart_adr_o, ea ? m_adr : 32'd0);
            chk("uart_dat", uart_dat_o, ea ? m_wd : 32'd0);
        end
    end

    // Slave responders: ack after lat cycles of stb (-1 = never)
    int usr_lat = -1, uart_lat = -1, usr_cnt = 0, uart_cnt = 0;
    bit spur = 0;

    always @(negedge clk) begin
        usr_ack_i = 0;
        uart_ack_i = 0;
        if (usr_stb_o) begin
            if (usr_cnt == usr_lat) usr_ack_i = 1;
            usr_cnt++;
        end else begin
            usr_cnt = 0;
        end
        if (uart_stb_o) begin
            if (uart_cnt == uart_lat) uart_ack_i = 1;
            uart_cnt++;
        end else begin
            uart_cnt = 0;
        end
        if (spur && uart_stb_o) usr_ack_i = 1;
    end

    // Called at a negedge; returns at the negedge of the ack cycle.
    task automatic xact(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int budget, output int lat,
                        output logic [31:0] rd, output logic be,
                        output logic [1:0] ec);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        lat = -1; rd = 0; be = 0; ec = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                lat = n; rd = wbs_dat_o; be = bus_err_o; ec = err_code_o;
                break;
            end
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] rd;
        logic be;
        logic [1:0] ec;

        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(wbs_ack_o), 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_ecode", 32'(err_code_o), 0);
        chk("rst_usr_stb", 32'(usr_stb_o), 0);
        rst = 0;

        // UART read, ack 3 cycles after stb
        @(negedge clk);
        uart_lat = 3; uart_dat_i = 32'h0000_0041;
        xact(0, 32'h3000_0004, 0, 4'hF, 20, lat, rd, be, ec);
        chk("uart_rd_lat", 32'(lat), 5);
        chk("uart_rd_dat", rd, 32'h41);
        chk("uart_rd_ec", 32'(ec), 0);

        // User write
        @(negedge clk);
        usr_lat = 1; usr_dat_i = 32'hFFFF_0000;
        xact(1, 32'h3800_0010, 32'h1234_5678, 4'hF, 20, lat, rd, be, ec);
        chk("usr_wr_lat", 32'(lat), 3);
        chk("usr_wr_dat", rd, 0);
        chk("usr_wr_be", 32'(be), 0);
        chk("usr_wr_ec", 32'(ec), 0);

        // Unmapped read
        @(negedge clk);
        xact(0, 32'h2000_0000, 0, 4'hF, 20, lat, rd, be, ec);
        chk("unm_lat", 32'(lat), 1);
        chk("unm_dat", rd, ERRD);
        chk("unm_be", 32'(be), 1);
        chk("unm_ec", 32'(ec), 1);

        // Hung UART
        @(negedge clk);
        uart_lat = -1;
        xact(0, 32'h3000_0008, 0, 4'hF, 1000, lat, rd, be, ec);
`ifdef WB_SLAVE_ROUTER_TIMEOUT_EN
        chk("to_lat", 32'(lat), 9);
        chk("to_dat", rd, ERRD);
        chk("to_be", 32'(be), 1);
        chk("to_ec", 32'(ec), 2);
        chk("to_uart_stb", 32'(uart_stb_o), 0);
`else
        chk("hang_noack", 32'(lat), 32'hFFFF_FFFF);
`endif

        // Master abort during FWD
        @(negedge clk);
        usr_lat = -1;
        xact(0, 32'h3400_0000, 0, 4'h3, 3, lat, rd, be, ec);
        chk("abort_noack", 32'(lat), 32'hFFFF_FFFF);
        @(negedge clk);
        chk("abort_stb", 32'(usr_stb_o), 0);
        chk("abort_ack", 32'(wbs_ack_o), 0);

        // Reset mid-FWD
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
        wbs_adr_i = 32'h3800_0020; wbs_dat_i = 32'h5555_AAAA; wbs_sel_i = 4'h1;
        repeat (2) @(negedge clk);
        chk("mid_usr_stb", 32'(usr_stb_o), 1);
        #2 rst = 1;
        #1;
        chk("rst_mid_stb", 32'(usr_stb_o), 0);
        chk("rst_mid_cyc", 32'(usr_cyc_o), 0);
        chk("rst_mid_adr", usr_adr_o, 0);
        chk("rst_mid_ack", 32'(wbs_ack_o), 0);
        @(negedge clk);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        rst = 0;

        // Back-to-back reads with spurious user ack during UART access
        @(negedge clk);
        usr_lat = 0; usr_dat_i = 32'hA5A5_0001;
        uart_lat = 1; uart_dat_i = 32'h0000_0055;
        spur = 1;
        xact(0, 32'h3200_0000, 0, 4'hF, 20, lat, rd, be, ec);
        chk("b2b1_lat", 32'(lat), 2);
        chk("b2b1_dat", rd, 32'hA5A5_0001);
        xact(0, 32'h3000_0000, 0, 4'hF, 20, lat, rd, be, ec);
        chk("b2b2_lat", 32'(lat), 4);
        chk("b2b2_dat", rd, 32'h55);
        spur = 0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
